xadc_temp_reader: RTL and testbench

XADC_TEMP_READER -- requirements
Module: xadc_temp_reader

---
 rtl/xadc_temp_reader.sv | 147 ++++++++++++++
 tb/tb_xadc_temp_reader.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xadc_temp_reader.sv
// Periodic XADC die-temperature read over DRP (addr 0x00), converted to 0.01 degC; result 2 cycles after drdy.
// Build option TEMP_AVG_EN: publish the mean of every 4 conversions instead of each conversion.
module xadc_temp_reader #(
  parameter int unsigned SAMPLE_DIV = 1000000,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               drp_den,
  output logic [6:0]         drp_daddr,
  output logic               drp_dwe,
  output logic [15:0]        drp_di,
  input  logic [15:0]        drp_do,
  input  logic               drp_drdy,
  output logic signed [31:0] temp_x100,
  output logic               temp_valid,
  output logic               drp_err
);

  localparam int unsigned       TW         = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [TW-1:0]     TMR_RELOAD = TW'(SAMPLE_DIV - 1);
  localparam logic [7:0]        WAIT_LAST  = 8'(TIMEOUT - 1);
  localparam logic [27:0]       SLOPE      = 28'd50398;
  localparam logic signed [31:0] OFFSET    = 32'sd27315;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, CONV} state_t;

  state_t             state_q, state_d;
  logic [TW-1:0]      tmr_q, tmr_d;
  logic               tick;
  logic [7:0]         wcnt_q, wcnt_d;
  logic [11:0]        code_q, code_d;
  logic signed [31:0] temp_q, temp_d;
  logic               vld_q, vld_d;
  logic               err_q, err_d;
  logic [27:0]        prod;
  logic [27:0]        scaled;
  logic signed [31:0] conv;
  logic [3:0]         unused_do_lsb;

`ifdef TEMP_AVG_EN
  logic signed [33:0] acc_q, acc_d;
  logic signed [33:0] sum;
  logic [1:0]         avg_cnt_q, avg_cnt_d;

  assign sum = acc_q + $signed({{2{conv[31]}}, conv});
`endif

  // Free-running sample timer; ticks that land outside IDLE are simply lost.
  assign tick  = (tmr_q == '0);
  assign tmr_d = tick ? TMR_RELOAD : (tmr_q - TW'(1));

  assign prod   = 28'(code_q) * SLOPE;
  assign scaled = prod >> 12;
  assign conv   = $signed({4'd0, scaled}) - OFFSET;

  assign unused_do_lsb = drp_do[3:0];

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    code_d    = code_q;
    temp_d    = temp_q;
    vld_d     = 1'b0;
    err_d     = 1'b0;
`ifdef TEMP_AVG_EN
    acc_d     = acc_q;
    avg_cnt_d = avg_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (tick) state_d = REQ;
      end
      REQ: begin
        wcnt_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // drdy on the final wait cycle still counts as a good read
        if (drp_drdy) begin
          code_d  = drp_do[15:4];
          state_d = CONV;
        end else if (wcnt_q == WAIT_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          wcnt_d = wcnt_q + 8'd1;
        end
      end
      CONV: begin
        state_d = IDLE;
`ifdef TEMP_AVG_EN
        if (avg_cnt_q == 2'd3) begin
          temp_d    = sum[33:2];  // sum >>> 2, low 32 bits
          vld_d     = 1'b1;
          acc_d     = '0;
          avg_cnt_d = 2'd0;
        end else begin
          acc_d     = sum;
          avg_cnt_d = avg_cnt_q + 2'd1;
        end
`else
        temp_d = conv;
        vld_d  = 1'b1;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      tmr_q     <= TMR_RELOAD;
      wcnt_q    <= '0;
      code_q    <= '0;
      temp_q    <= '0;
      vld_q     <= 1'b0;
      err_q     <= 1'b0;
`ifdef TEMP_AVG_EN
      acc_q     <= '0;
      avg_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      wcnt_q    <= wcnt_d;
      code_q    <= code_d;
      temp_q    <= temp_d;
      vld_q     <= vld_d;
      err_q     <= err_d;
`ifdef TEMP_AVG_EN
      acc_q     <= acc_d;
      avg_cnt_q <= avg_cnt_d;
`endif
    end
  end

  assign drp_den    = (state_q == REQ);
  assign drp_daddr  = 7'h00;
  assign drp_dwe    = 1'b0;
  assign drp_di     = 16'h0000;
  assign temp_x100  = temp_q;
  assign temp_valid = vld_q;
  assign drp_err    = err_q;

endmodule

// File: tb/tb_xadc_temp_reader.sv
// Bench for xadc_temp_reader: DRP responder with random codes/delays against an arithmetic temperature model.
`timescale 1ns/1ps
module tb_xadc_temp_reader;

  localparam int SD  = 16;
  localparam int TO  = 8;
  localparam int TO2 = 40;

  logic clk = 1'b0;
  logic rst_n;

  logic               den, dwe, drdy, vld, err;
  logic [6:0]         daddr;
  logic [15:0]        di, dout;
  logic signed [31:0] temp;

  logic               den2, dwe2, drdy2, vld2, err2;
  logic [6:0]         daddr2;
  logic [15:0]        di2, dout2;
  logic signed [31:0] temp2;

  int     total = 0;
  int     bad   = 0;
  int     model_temp;
  longint model_sum;
  int     model_cnt;

  always #5 clk = ~clk;

  xadc_temp_reader #(.SAMPLE_DIV(SD), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .drp_den(den), .drp_daddr(daddr), .drp_dwe(dwe),
    .drp_di(di), .drp_do(dout), .drp_drdy(drdy), .temp_x100(temp),
    .temp_valid(vld), .drp_err(err)
  );

  // Long timeout so that sample ticks fall inside WAIT.
  xadc_temp_reader #(.SAMPLE_DIV(SD), .TIMEOUT(TO2)) dut_drop (
    .clk(clk), .rst_n(rst_n), .drp_den(den2), .drp_daddr(daddr2), .drp_dwe(dwe2),
    .drp_di(di2), .drp_do(dout2), .drp_drdy(drdy2), .temp_x100(temp2),
    .temp_valid(vld2), .drp_err(err2)
  );

  function automatic int conv_ref(input logic [11:0] code);
    longint v;
    v = longint'(code) * 50398 / 4096 - 27315;
    return int'(v);
  endfunction

  task automatic model_reset();
    model_temp = 0;
    model_sum  = 0;
    model_cnt  = 0;
  endtask

  task automatic model_conv(input logic [11:0] code, output bit vld_exp);
`ifdef TEMP_AVG_EN
    model_sum += longint'(conv_ref(code));
    model_cnt++;
    if (model_cnt == 4) begin
      model_temp = int'(model_sum >>> 2);
      model_sum  = 0;
      model_cnt  = 0;
      vld_exp    = 1'b1;
    end else begin
      vld_exp = 1'b0;
    end
`else
    model_temp = conv_ref(code);
    vld_exp    = 1'b1;
`endif
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int n;
    rst_n = 1'b0; drdy = 1'b1; dout = 16'hFFFF; drdy2 = 1'b1; dout2 = 16'hFFFF;
    repeat (3) step();
    total++;
    if (den !== 1'b0 || vld !== 1'b0 || err !== 1'b0 || daddr !== 7'h00 || temp !== 32'sd0) begin
      bad++;
      $display("FAIL reset_outputs: den=%b vld=%b err=%b daddr=%h temp=%0d, want all zero", den, vld, err, daddr, temp);
    end
    total++;
    if (dwe !== 1'b0 || di !== 16'h0000) begin
      bad++;
      $display("FAIL reset_write_port: dwe=%b di=%h, want 0/0000", dwe, di);
    end
    drdy = 1'b0; drdy2 = 1'b0;
    rst_n = 1'b1;
    model_reset();
    n = -1;
    for (int i = 1; i <= 3 * SD; i++) begin
      step();
      if (den === 1'b1) begin n = i; break; end
    end
    total++;
    if (n != SD) begin
      bad++;
      $display("FAIL first_den_after_reset: den after %0d cycles, want %0d", n, SD);
    end
  endtask

  task automatic do_read(input logic [11:0] code, input int dly, input bit spur, input string tag);
    int n;
    int stray;
    bit ev;
    stray = 0;
    for (n = 0; n < 4 * SD && den !== 1'b1; n++) begin
      drdy = spur ? 1'($urandom_range(0, 1)) : 1'b0;
      dout = 16'($urandom);
      step();
      drdy = 1'b0;
      if (vld !== 1'b0) stray++;
    end
    total++;
    if (den !== 1'b1 || stray != 0) begin
      bad++;
      $display("FAIL %s_den_wait: den=%b stray_valid=%0d after %0d cycles, want den=1 stray=0", tag, den, stray, n);
      return;
    end
    total++;
    if (daddr !== 7'h00 || dwe !== 1'b0 || di !== 16'h0000) begin
      bad++;
      $display("FAIL %s_den_fields: daddr=%h dwe=%b di=%h, want 00/0/0000", tag, daddr, dwe, di);
    end
    if (spur) begin drdy = 1'b1; dout = 16'($urandom); end
    step();
    drdy = 1'b0;
    for (int k = 1; k < dly; k++) step();
    total++;
    if (den !== 1'b0 || err !== 1'b0 || vld !== 1'b0) begin
      bad++;
      $display("FAIL %s_in_wait: den=%b err=%b vld=%b, want 0/0/0", tag, den, err, vld);
    end
    drdy = 1'b1;
    dout = {code, 4'($urandom)};
    step();
    drdy = 1'b0;
    total++;
    if (vld !== 1'b0) begin
      bad++;
      $display("FAIL %s_early_valid: vld=%b one cycle after drdy, want 0", tag, vld);
    end
    step();
    model_conv(code, ev);
    total++;
    if (vld !== ev || temp !== model_temp || err !== 1'b0) begin
      bad++;
      $display("FAIL %s_result: code=%0d vld=%b temp=%0d err=%b, want vld=%b temp=%0d err=0",
               tag, code, vld, temp, err, ev, model_temp);
    end
    step();
    total++;
    if (vld !== 1'b0) begin
      bad++;
      $display("FAIL %s_valid_width: vld=%b three cycles after drdy, want 0", tag, vld);
    end
  endtask

  task automatic test_known();
    do_read(12'd2500, 3, 1'b0, "known_2500_a");
    do_read(12'd2500, 1, 1'b0, "known_2500_b");
    do_read(12'd2500, 5, 1'b1, "known_2500_c");
    do_read(12'd2500, 2, 1'b0, "known_2500_d");
    do_read(12'd0,    3, 1'b0, "known_0_a");
    do_read(12'd0,    4, 1'b1, "known_0_b");
    do_read(12'd4095, 3, 1'b0, "known_4095_a");
    do_read(12'd4095, TO, 1'b0, "known_4095_b");
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++)
      do_read(12'($urandom), $urandom_range(1, TO), 1'($urandom_range(0, 1)), "random");
    do_read(12'($urandom), TO, 1'b1, "drdy_at_timeout");
  endtask

  task automatic test_timeout();
    int n, errs, first_err, stray, hold;
    stray = 0;
    for (n = 0; n < 4 * SD && den !== 1'b1; n++) begin
      drdy = 1'($urandom_range(0, 1));
      step();
      drdy = 1'b0;
      if (vld !== 1'b0) stray++;
    end
    total++;
    if (den !== 1'b1) begin
      bad++;
      $display("FAIL timeout_den_wait: den=%b after %0d cycles, want 1", den, n);
      return;
    end
    hold = model_temp;
    errs = 0;
    first_err = -1;
    for (int k = 1; k <= TO + 2; k++) begin
      step();
      if (err === 1'b1) begin
        errs++;
        if (first_err < 0) first_err = k;
      end
      if (vld !== 1'b0) stray++;
    end
    total++;
    if (errs != 1 || first_err != TO + 1) begin
      bad++;
      $display("FAIL timeout_err: %0d err pulses first at +%0d, want 1 at +%0d", errs, first_err, TO + 1);
    end
    total++;
    if (temp !== hold || stray != 0) begin
      bad++;
      $display("FAIL timeout_hold: temp=%0d stray_valid=%0d, want temp=%0d stray=0", temp, stray, hold);
    end
    for (n = 0; n < 4 * SD && den !== 1'b1; n++) begin
      drdy = 1'($urandom_range(0, 1));
      step();
      drdy = 1'b0;
    end
    total++;
    if (n != SD - TO - 2 || den !== 1'b1) begin
      bad++;
      $display("FAIL timeout_next_den: den=%b after %0d cycles, want 1 after %0d", den, n, SD - TO - 2);
    end
  endtask

  task automatic test_drop();
    int n, dens, errs, at, err_at;
    bit v22;
    logic signed [31:0] t22;
    for (n = 0; n < 8 * SD && den2 !== 1'b1; n++) step();
    total++;
    if (den2 !== 1'b1 || daddr2 !== 7'h00 || dwe2 !== 1'b0 || di2 !== 16'h0000) begin
      bad++;
      $display("FAIL drop_sync: den2=%b daddr2=%h dwe2=%b di2=%h, want 1/00/0/0000", den2, daddr2, dwe2, di2);
      return;
    end
    dens = 0; errs = 0; at = -1; v22 = 1'b0; t22 = '0;
    for (int k = 1; k <= 2 * SD; k++) begin
      step();
      drdy2 = (k == 20);
      dout2 = 16'h9C40;
      if (den2 === 1'b1) begin dens++; if (at < 0) at = k; end
      if (err2 === 1'b1) errs++;
      if (k == 22) begin v22 = vld2; t22 = temp2; end
    end
    drdy2 = 1'b0;
    total++;
    if (dens != 1 || at != 2 * SD || errs != 0) begin
      bad++;
      $display("FAIL drop_late_reply: dens=%0d first at +%0d errs=%0d, want 1 at +%0d errs=0", dens, at, errs, 2 * SD);
    end
`ifndef TEMP_AVG_EN
    total++;
    if (v22 !== 1'b1 || t22 !== conv_ref(12'd2500)) begin
      bad++;
      $display("FAIL drop_late_result: vld=%b temp=%0d, want 1/%0d", v22, t22, conv_ref(12'd2500));
    end
`endif
    errs = 0; err_at = -1; at = -1;
    for (int k = 1; k <= 4 * SD; k++) begin
      step();
      if (err2 === 1'b1) begin errs++; err_at = k; end
      if (den2 === 1'b1) begin at = k; break; end
    end
    total++;
    if (errs != 1 || err_at != TO2 + 1 || at != 3 * SD) begin
      bad++;
      $display("FAIL drop_timeout: errs=%0d at +%0d next den +%0d, want 1 at +%0d den +%0d",
               errs, err_at, at, TO2 + 1, 3 * SD);
    end
  endtask

  task automatic test_reset_wait();
    int n, stray;
    for (n = 0; n < 4 * SD && den !== 1'b1; n++) step();
    step();
    step();
    rst_n = 1'b0;
    #1;
    total++;
    if (den !== 1'b0 || vld !== 1'b0 || err !== 1'b0 || temp !== 32'sd0 || daddr !== 7'h00) begin
      bad++;
      $display("FAIL reset_in_wait: den=%b vld=%b err=%b temp=%0d daddr=%h, want all zero", den, vld, err, temp, daddr);
    end
    step();
    step();
    rst_n = 1'b1;
    model_reset();
    drdy = 1'b1;
    dout = 16'h9C40;
    n = -1;
    stray = 0;
    for (int i = 1; i <= 3 * SD; i++) begin
      step();
      drdy = 1'b0;
      if (vld !== 1'b0 || err !== 1'b0 || temp !== 32'sd0) stray++;
      if (den === 1'b1) begin n = i; break; end
    end
    total++;
    if (n != SD || stray != 0) begin
      bad++;
      $display("FAIL stale_drdy_after_reset: den after %0d cycles stray=%0d, want %0d and 0", n, stray, SD);
    end
    do_read(12'($urandom), $urandom_range(1, TO), 1'b0, "after_reset");
  endtask

  initial begin
    rst_n = 1'b0;
    drdy  = 1'b0; dout  = 16'h0000;
    drdy2 = 1'b0; dout2 = 16'h0000;
    model_reset();
    test_reset();
    test_known();
    test_random();
    test_timeout();
    test_drop();
    test_reset_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation exceeded time limit, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
